// File: rtl/pcihello_hex_pkg.sv
// Shared types and constants for the PIO hex display scanner.
package pcihello_hex_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/pcihello_hex_scan_dec.sv
// Combinational nibble to active-low 7-segment decoder.
module hex7seg_dec
    import pcihello_hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n_c
);

    assign seg_n_c = SEG_LUT[nibble];

endmodule

// File: rtl/pcihello_hex_scan.sv
// Scans a snapshot of the hex PIO value onto a multiplexed 7-segment display,
// MSD first, with optional leading-zero blanking and an all-off guard gap.
module pcihello_hex_scan
    import pcihello_hex_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_done
);

    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_MAX = (TICK_DIV > GUARD_CYCLES) ? TICK_DIV : GUARD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(NUM_DIGITS - 1);

    state_t                  state, state_d;
    logic [IDX_W-1:0]        idx, idx_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic                    lz_active, lz_d;
    logic                    load_en;
    logic                    advance;
    logic [VAL_W-1:0]        val_snap;
    logic [NUM_DIGITS-1:0]   dp_snap;
    logic                    lz_snap;

    logic [3:0]              nibble_c;
    logic [6:0]              seg_dec_c;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic                    frame_done_d;

    assign nibble_c = 4'(val_snap >> {idx, 2'b00});

    hex7seg_dec u_dec (
        .nibble  (nibble_c),
        .seg_n_c (seg_dec_c)
    );

    // Next-state, counter and blanking-flag logic
    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt + 1'b1;
        lz_d    = lz_active;
        load_en = 1'b0;
        advance = 1'b0;
        case (state)
            ST_LOAD: begin
                load_en = 1'b1;
                lz_d    = lz_blank_en;
                idx_d   = IDX_TOP;
                cnt_d   = '0;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (cnt == TICK_LAST) begin
                    cnt_d = '0;
                    if (nibble_c != 4'd0 || idx == '0) begin
                        lz_d = 1'b0;
                    end
                    if (GUARD_CYCLES > 0) begin
                        state_d = ST_GUARD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
        endcase
        if (advance) begin
            if (idx == '0) begin
                state_d = ST_LOAD;
            end else begin
                idx_d   = idx - 1'b1;
                state_d = ST_SHOW;
            end
        end
    end

    // Display drive for the state being occupied; registered below
    always_comb begin
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        sel_d        = '1;
        frame_done_d = 1'b0;
        case (state)
            ST_LOAD: frame_done_d = 1'b1;
            ST_SHOW: begin
                sel_d[idx] = 1'b0;
                dp_d       = ~dp_snap[idx];
                if (!(lz_active && nibble_c == 4'd0 && idx != '0)) begin
                    seg_d = seg_dec_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_LOAD;
            idx         <= IDX_TOP;
            cnt         <= '0;
            lz_active   <= 1'b0;
            val_snap    <= '0;
            dp_snap     <= '0;
            lz_snap     <= 1'b0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            digit_sel_n <= '1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            lz_active   <= lz_d;
            seg_n       <= seg_d;
            dp_n        <= dp_d;
            digit_sel_n <= sel_d;
            frame_done  <= frame_done_d;
            if (load_en) begin
                val_snap <= value_in;
                dp_snap  <= dp_in;
                lz_snap  <= lz_blank_en;
            end
        end
    end

    // lz_snap is kept as the frame's captured blanking request alongside the data
    logic unused_c;
    assign unused_c = lz_snap;

endmodule

// File: tb/tb_pcihello_hex_scan.sv
// Directed bench for the hex display scanner (4 digits, 4-cycle tick, 1 guard).
module tb_pcihello_hex_scan;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        lz_blank_en;
    logic [6:0]  seg_n,  seg_n0;
    logic        dp_n,   dp_n0;
    logic [3:0]  digit_sel_n, digit_sel_n0;
    logic        frame_done,  frame_done0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pcihello_hex_scan #(.NUM_DIGITS(4), .TICK_DIV(4), .GUARD_CYCLES(1)) dut (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in),
        .lz_blank_en(lz_blank_en), .seg_n(seg_n), .dp_n(dp_n),
        .digit_sel_n(digit_sel_n), .frame_done(frame_done)
    );

    pcihello_hex_scan #(.NUM_DIGITS(4), .TICK_DIV(4), .GUARD_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in),
        .lz_blank_en(lz_blank_en), .seg_n(seg_n0), .dp_n(dp_n0),
        .digit_sel_n(digit_sel_n0), .frame_done(frame_done0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sel, input logic [6:0] seg,
                           input logic dp, input logic fd);
        chk({tag, ".sel"}, 32'(digit_sel_n), 32'(sel));
        chk({tag, ".seg"}, 32'(seg_n), 32'(seg));
        chk({tag, ".dp"},  32'(dp_n), 32'(dp));
        chk({tag, ".fd"},  32'(frame_done), 32'(fd));
    endtask

    task automatic load_step(input string tag);
        step();
        chk_out(tag, 4'hF, 7'h7F, 1'b1, 1'b1);
    endtask

    // One digit: TICK_DIV lit cycles then one guard cycle
    task automatic digit(input string tag, input int d, input logic [6:0] seg, input logic dp);
        logic [3:0] sel;
        sel    = 4'hF;
        sel[d] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out(tag, sel, seg, dp, 1'b0);
        end
        step();
        chk_out({tag, ".guard"}, 4'hF, 7'h7F, 1'b1, 1'b0);
    endtask

    initial begin
        int period;
        int off_cnt;

        reset_n     = 1'b0;
        value_in    = 16'h12AF;
        dp_in       = 4'b0000;
        lz_blank_en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_out("rst0", 4'hF, 7'h7F, 1'b1, 1'b0);
        chk("rst0.g0sel", 32'(digit_sel_n0), 32'hF);
        chk("rst0.g0fd",  32'(frame_done0), 32'h0);

        // Start, then reset for 3 cycles in the middle of digit 3
        reset_n = 1'b1;
        load_step("start");
        step();
        chk_out("d3a", 4'b0111, 7'h79, 1'b1, 1'b0);
        step();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("midrst", 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        reset_n = 1'b1;
        load_step("restart");
        digit("f1.d3", 3, 7'h79, 1'b1);
        digit("f1.d2", 2, 7'h24, 1'b1);
        digit("f1.d1", 1, 7'h08, 1'b1);
        digit("f1.d0", 0, 7'h0E, 1'b1);

        // Frame period; 00A5 with blanking is loaded at the period's end
        load_step("f2.load");
        value_in    = 16'h00A5;
        lz_blank_en = 1'b1;
        period = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            period++;
            if (frame_done) break;
        end
        chk("period", 32'(period), 32'd21);

        value_in = 16'h0000;
        dp_in    = 4'b0100;
        digit("lz.d3", 3, 7'h7F, 1'b1);
        digit("lz.d2", 2, 7'h7F, 1'b1);
        digit("lz.d1", 1, 7'h08, 1'b1);
        digit("lz.d0", 0, 7'h12, 1'b1);

        load_step("zero.load");
        value_in    = 16'h1111;
        dp_in       = 4'b0000;
        lz_blank_en = 1'b0;
        digit("z.d3", 3, 7'h7F, 1'b1);
        digit("z.d2", 2, 7'h7F, 1'b0);
        digit("z.d1", 1, 7'h7F, 1'b1);
        digit("z.d0", 0, 7'h40, 1'b1);

        // Mid-frame value change must not tear the displayed frame
        load_step("tear.load");
        digit("t.d3", 3, 7'h79, 1'b1);
        step();
        chk_out("t.d2a", 4'b1011, 7'h79, 1'b1, 1'b0);
        value_in = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("t.d2", 4'b1011, 7'h79, 1'b1, 1'b0);
        end
        step();
        chk_out("t.d2.guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        digit("t.d1", 1, 7'h79, 1'b1);
        digit("t.d0", 0, 7'h79, 1'b1);
        load_step("t2.load");
        digit("t2.d3", 3, 7'h24, 1'b1);
        digit("t2.d2", 2, 7'h24, 1'b1);

        // Guard-less build: frame length and no all-off gap between digits
        period = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_done0) break;
        end
        chk("g0.sync", 32'(frame_done0), 32'h1);
        off_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            period++;
            if (frame_done0) break;
            if (digit_sel_n0 == 4'hF) off_cnt++;
        end
        chk("g0.period", 32'(period), 32'd17);
        chk("g0.offcyc", 32'(off_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
